// File: rtl/tlb_flush_machine_if.sv
// rtl/tlb_flush_machine_if.sv - TLB entry types and the flush machine request/TLB port bundle
package tlb_flush_pkg;
  typedef struct packed {
    logic [27:0] ppn;
    logic [3:0]  perm;
    logic        v;
  } pte_t;

  typedef struct packed {
    logic [47:0] vpn;
    logic        lock;
    pte_t        pte;
  } tlb_entry_t;
endpackage

interface tlb_flush_machine_if #(parameter int WID = 9);
  import tlb_flush_pkg::*;

  logic             flush_req;
  logic [1:0]       flush_mode;
  logic [47:0]      flush_vpn;
  logic             busy;
  logic             done;
  logic             rd_en;
  logic [WID-1:0]   rd_entry_no;
  tlb_entry_t       rd_entry;
  logic             wr_en;
  logic [WID-1:0]   wr_entry_no;
  tlb_entry_t       wr_entry;
`ifdef TLB_FLUSH_COUNT_EN
  logic [WID:0]     flush_count;

  modport slave  (input  flush_req, flush_mode, flush_vpn, rd_entry,
                  output busy, done, rd_en, rd_entry_no, wr_en, wr_entry_no, wr_entry, flush_count);
  modport master (output flush_req, flush_mode, flush_vpn, rd_entry,
                  input  busy, done, rd_en, rd_entry_no, wr_en, wr_entry_no, wr_entry, flush_count);
`else
  modport slave  (input  flush_req, flush_mode, flush_vpn, rd_entry,
                  output busy, done, rd_en, rd_entry_no, wr_en, wr_entry_no, wr_entry);
  modport master (output flush_req, flush_mode, flush_vpn, rd_entry,
                  input  busy, done, rd_en, rd_entry_no, wr_en, wr_entry_no, wr_entry);
`endif
endinterface

// File: rtl/tlb_flush_machine.sv
// rtl/tlb_flush_machine.sv - sweeps all TLB entries, clearing pte.v on matching ones
// Optional TLB_FLUSH_COUNT_EN adds flush_count (entries invalidated by the last sweep).
module tlb_flush_machine
  import tlb_flush_pkg::*;
#(
  parameter int TLB_ENTRIES = 512,
  parameter int RD_LATENCY  = 1,
  parameter int WID         = $clog2(TLB_ENTRIES)
) (
  input  logic               clk,
  input  logic               rst,
  tlb_flush_machine_if.slave bus
);

  typedef enum logic [1:0] {IDLE, SCAN, DRAIN, DONE} state_t;

  state_t                          state, state_nxt;
  logic [WID:0]                    cnt;
  logic [WID:0]                    cnt_inc;
  logic [1:0]                      mode_q;
  logic [47:0]                     vpn_q;
  logic [1:0]                      drain_cnt;
  logic [RD_LATENCY-1:0]           pipe_v;
  logic [RD_LATENCY-1:0][WID-1:0]  pipe_idx;
  logic                            accept;
  logic                            hit;
  tlb_entry_t                      ret_d;
  tlb_entry_t                      cleared;
`ifdef TLB_FLUSH_COUNT_EN
  logic [WID:0]                    count_q;
`endif

  assign cnt_inc = cnt + 1'b1;
  assign accept  = (state == IDLE) && bus.flush_req;
  assign ret_d   = bus.rd_entry;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      mode_q    <= '0;
      vpn_q     <= '0;
      drain_cnt <= '0;
      pipe_v    <= '0;
      pipe_idx  <= '0;
`ifdef TLB_FLUSH_COUNT_EN
      count_q   <= '0;
`endif
    end else begin
      state <= state_nxt;
      if (accept) begin
        cnt    <= '0;
        mode_q <= bus.flush_mode;
        vpn_q  <= bus.flush_vpn;
      end else if (state == SCAN) begin
        cnt <= cnt_inc;
      end
      if (state == SCAN)
        drain_cnt <= '0;
      else if (state == DRAIN)
        drain_cnt <= drain_cnt + 2'd1;
      // Index/valid ride alongside the RAM read so returned data knows its entry
      pipe_v[0]   <= bus.rd_en;
      pipe_idx[0] <= bus.rd_entry_no;
      for (int i = RD_LATENCY - 1; i > 0; i--) begin
        pipe_v[i]   <= pipe_v[i-1];
        pipe_idx[i] <= pipe_idx[i-1];
      end
`ifdef TLB_FLUSH_COUNT_EN
      if (accept)
        count_q <= '0;
      else if (hit)
        count_q <= count_q + 1'b1;
`endif
    end
  end

  always_comb begin
    state_nxt       = state;
    bus.rd_en       = 1'b0;
    bus.rd_entry_no = '0;
    bus.busy        = (state != IDLE);
    bus.done        = (state == DONE);
    case (state)
      IDLE:  if (bus.flush_req) state_nxt = SCAN;
      SCAN: begin
        bus.rd_en       = 1'b1;
        bus.rd_entry_no = cnt[WID-1:0];
        if (cnt_inc[WID]) state_nxt = DRAIN;
      end
      DRAIN: if (drain_cnt == 2'(RD_LATENCY - 1)) state_nxt = DONE;
      DONE:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Mode 11 is treated as 00: neither the lock override nor the vpn compare applies
  always_comb begin
    hit = pipe_v[RD_LATENCY-1] & ret_d.pte.v
        & ((mode_q == 2'b01) | !ret_d.lock)
        & ((mode_q != 2'b10) | (ret_d.vpn == vpn_q));
    cleared       = ret_d;
    cleared.pte.v = 1'b0;
    bus.wr_en       = hit;
    bus.wr_entry_no = hit ? pipe_idx[RD_LATENCY-1] : '0;
    bus.wr_entry    = hit ? cleared : '0;
  end

`ifdef TLB_FLUSH_COUNT_EN
  assign bus.flush_count = count_q;
`endif

endmodule

// File: tb/tb_tlb_flush_machine.sv
// tb/tb_tlb_flush_machine.sv - directed bench for tlb_flush_machine at read latency 1 and 3
module tb_tlb_flush_machine;
  import tlb_flush_pkg::*;

  localparam int N   = 512;
  localparam int WID = 9;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  tlb_flush_machine_if #(.WID(WID)) b1 ();
  tlb_flush_machine_if #(.WID(WID)) b3 ();

  tlb_flush_machine #(.TLB_ENTRIES(N), .RD_LATENCY(1)) dut1 (.clk(clk), .rst(rst), .bus(b1.slave));
  tlb_flush_machine #(.TLB_ENTRIES(N), .RD_LATENCY(3)) dut3 (.clk(clk), .rst(rst), .bus(b3.slave));

  tlb_entry_t mem1 [N];
  tlb_entry_t mem3 [N];
  tlb_entry_t p0, p1;

  always @(posedge clk) begin
    if (b1.rd_en) b1.rd_entry <= mem1[b1.rd_entry_no];
    if (b1.wr_en) mem1[b1.wr_entry_no] = b1.wr_entry;
  end

  always @(posedge clk) begin
    if (b3.rd_en) p0 <= mem3[b3.rd_entry_no];
    p1          <= p0;
    b3.rd_entry <= p1;
    if (b3.wr_en) mem3[b3.wr_entry_no] = b3.wr_entry;
  end

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string tag, input longint obs, input longint exp);
    n_total++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  task automatic preload(input int lock_from);
    for (int i = 0; i < N; i++) begin
      mem1[i].vpn       = 48'(i) + 48'h1000;
      mem1[i].lock      = (i >= lock_from);
      mem1[i].pte.ppn   = 28'(i * 3);
      mem1[i].pte.perm  = 4'hA;
      mem1[i].pte.v     = 1'b1;
      mem3[i]           = mem1[i];
    end
  endtask

  function automatic int valid1();
    int c = 0;
    for (int i = 0; i < N; i++) if (mem1[i].pte.v) c++;
    return c;
  endfunction

  int sw_cycles, sw_writes, sw_first, sw_last, sw_dones, sw_late_busy;

  task automatic sweep1(input logic [1:0] mode, input logic [47:0] vpn, input int repulse);
    sw_cycles = 0; sw_writes = 0; sw_first = -1; sw_last = -1; sw_dones = 0; sw_late_busy = 0;
    @(negedge clk);
    b1.flush_req  = 1'b1;
    b1.flush_mode = mode;
    b1.flush_vpn  = vpn;
    for (int k = 1; k <= N + 20; k++) begin
      @(negedge clk);
      b1.flush_req = (k == repulse);
      if (b1.wr_en) begin
        sw_writes++;
        if (sw_first < 0) sw_first = int'(b1.wr_entry_no);
        sw_last = int'(b1.wr_entry_no);
      end
      if (b1.done) begin
        sw_dones++;
        if (sw_cycles == 0) sw_cycles = k;
      end
      if (sw_cycles != 0 && k > sw_cycles && b1.busy) sw_late_busy++;
      if (sw_cycles != 0 && k >= sw_cycles + 3) break;
    end
  endtask

  int k;
  int bad;
  int hist [N + 24];

  initial begin
    b1.flush_req = 1'b0; b1.flush_mode = 2'b00; b1.flush_vpn = '0;
    b3.flush_req = 1'b0; b3.flush_mode = 2'b00; b3.flush_vpn = '0;
    preload(448);
    repeat (3) @(negedge clk);
    check("rst_busy", b1.busy, 0);
    check("rst_done", b1.done, 0);
    check("rst_rd_en", b1.rd_en, 0);
    check("rst_wr_en", b1.wr_en, 0);
`ifdef TLB_FLUSH_COUNT_EN
    check("rst_count", b1.flush_count, 0);
`endif
    rst = 1'b0;

    // 1: mode 00, upper 64 entries locked
    sweep1(2'b00, 48'h0, -1);
    check("t1_done_clk", sw_cycles, 514);
    check("t1_writes", sw_writes, 448);
    check("t1_first", sw_first, 0);
    check("t1_last", sw_last, 447);
    check("t1_valid_left", valid1(), 64);
    check("t1_e447_v", mem1[447].pte.v, 0);
    check("t1_e448_v", mem1[448].pte.v, 1);
    check("t1_e10_ppn", mem1[10].pte.ppn, 30);
    check("t1_e10_vpn", mem1[10].vpn, 48'h100A);
`ifdef TLB_FLUSH_COUNT_EN
    check("t1_count", b1.flush_count, 448);
`endif

    // 2: mode 01 clears locked entries too
    preload(448);
    sweep1(2'b01, 48'h0, -1);
    check("t2_writes", sw_writes, 512);
    check("t2_last", sw_last, 511);
    check("t2_valid_left", valid1(), 0);
    check("t2_e500_lock", mem1[500].lock, 1);
`ifdef TLB_FLUSH_COUNT_EN
    check("t2_count", b1.flush_count, 512);
`endif

    // 3: vpn match skips the locked twin at 460
    preload(448);
    mem1[3].vpn   = 48'h1FF;
    mem1[460].vpn = 48'h1FF;
    sweep1(2'b10, 48'h1FF, -1);
    check("t3_writes", sw_writes, 1);
    check("t3_first", sw_first, 3);
    check("t3_e3_v", mem1[3].pte.v, 0);
    check("t3_e3_vpn", mem1[3].vpn, 48'h1FF);
    check("t3_e460_v", mem1[460].pte.v, 1);
    check("t3_valid_left", valid1(), 511);
`ifdef TLB_FLUSH_COUNT_EN
    check("t3_count", b1.flush_count, 1);
`endif

    // reserved mode behaves as 00
    preload(448);
    sweep1(2'b11, 48'h0, -1);
    check("t3b_writes", sw_writes, 448);

    // 4a: re-pulse mid-sweep is ignored
    preload(448);
    sweep1(2'b00, 48'h0, 100);
    check("t4_dones", sw_dones, 1);
    check("t4_done_clk", sw_cycles, 514);
    check("t4_late_busy", sw_late_busy, 0);

    // 4b: request held through DONE restarts after one idle clock
    preload(448);
    @(negedge clk);
    b1.flush_req = 1'b1;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!b1.done && k < N + 20);
    check("t4_hold_done_clk", k, 514);
    @(negedge clk);
    check("t4_idle_gap", b1.busy, 0);
    @(negedge clk);
    check("t4_restart_busy", b1.busy, 1);
    check("t4_restart_idx", b1.rd_entry_no, 0);
    b1.flush_req = 1'b0;
    k = 1;
    while (!b1.done && k < N + 20) begin
      @(negedge clk);
      k++;
    end
    check("t4_second_done_clk", k, 514);

    // 5: reset mid-sweep
    preload(N);
    @(negedge clk);
    b1.flush_req = 1'b1;
    b1.flush_mode = 2'b00;
    for (int i = 1; i <= 200; i++) begin
      @(negedge clk);
      b1.flush_req = 1'b0;
    end
    rst = 1'b1;
    @(negedge clk);
    check("t5_busy", b1.busy, 0);
    check("t5_wr_en", b1.wr_en, 0);
    check("t5_rd_en", b1.rd_en, 0);
`ifdef TLB_FLUSH_COUNT_EN
    check("t5_count", b1.flush_count, 0);
`endif
    rst = 1'b0;
    check("t5_e198_v", mem1[198].pte.v, 0);
    check("t5_e199_v", mem1[199].pte.v, 1);
    check("t5_valid_left", valid1(), 313);

    // 6: read latency 3
    preload(N);
    for (int i = 0; i < N + 24; i++) hist[i] = -1;
    @(negedge clk);
    b3.flush_req = 1'b1;
    b3.flush_mode = 2'b00;
    k = 0; bad = 0; sw_writes = 0; sw_cycles = 0;
    for (int i = 1; i <= N + 20; i++) begin
      @(negedge clk);
      b3.flush_req = 1'b0;
      if (b3.rd_en) hist[i] = int'(b3.rd_entry_no);
      if (b3.wr_en) begin
        sw_writes++;
        if (i < 4 || hist[i-3] != int'(b3.wr_entry_no)) bad++;
      end
      if (b3.done) begin
        sw_cycles = i;
        break;
      end
    end
    check("t6_done_clk", sw_cycles, 516);
    check("t6_writes", sw_writes, 512);
    check("t6_idx_lag", bad, 0);
    check("t6_e511_v", mem3[511].pte.v, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
